// File: rtl/sdma_req_arbiter_pkg.sv
// sdma_req_arbiter_pkg: shared FSM encodings and widths for the SDMA request arbiter family.
package sdma_req_arbiter_pkg;
  localparam int IW = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;
  function automatic logic [3:0] wrap_idx(input logic [3:0] s, input int n);
    return (s >= 4'(n)) ? s - 4'(n) : s;
  endfunction
endpackage

// File: rtl/sdma_rr_pick.sv
// sdma_rr_pick: combinational round-robin picker, first eligible requester after ptr (wrapping).
module sdma_rr_pick
  import sdma_req_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  logic [3:0]   off;
  logic [3:0]   s;
  always_comb begin
    rot = N'({eligible, eligible} >> (ptr + 3'd1));
    off = '0;
    for (int j = N - 1; j >= 0; j--) if (rot[j]) off = 4'(j);
    any = |rot;
    s   = wrap_idx(4'(ptr) + 4'd1 + off, N);
    idx = 3'(s);
    win = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/sdma_req_arbiter.sv
// sdma_req_arbiter: round-robin sharing of one SDMA channel among N_REQ fabric requesters, with timeout.
module sdma_req_arbiter
  import sdma_req_arbiter_pkg::*;
#(
  parameter int             N_REQ       = 4,
  parameter int             TO_W        = 16,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 16'hFFF
) (
  input  logic             WB_CLK,
  input  logic             WB_RST_n,
  input  logic [N_REQ-1:0] Req_i,
  input  logic [N_REQ-1:0] Sreq_i,
  input  logic [N_REQ-1:0] Mask_i,
  output logic [N_REQ-1:0] Grant_o,
  output logic [N_REQ-1:0] Done_o,
  output logic             SDMA_Req_o,
  output logic             SDMA_Sreq_o,
  input  logic             SDMA_Done_i,
  input  logic             SDMA_Active_i,
  output logic             Err_Intr_o,
  output logic [2:0]       Err_Src_o
);
  logic [2:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    widx;
  logic [TO_W-1:0]  cnt;
  logic [N_REQ-1:0] win;
  logic [IW-1:0]    idx;
  logic             any;
  logic             owner_req;
  sdma_rr_pick #(.N(N_REQ)) u_pick (
    .eligible(Mask_i & (Req_i | Sreq_i)),
    .ptr     (ptr),
    .win     (win),
    .idx     (idx),
    .any     (any)
  );
  assign owner_req = |((Req_i | Sreq_i) & Grant_o);
  always_ff @(posedge WB_CLK or negedge WB_RST_n)
    if (!WB_RST_n) begin
      state       <= ST_IDLE;
      ptr         <= IW'(N_REQ - 1);
      widx        <= '0;
      cnt         <= '0;
      Grant_o     <= '0;
      Done_o      <= '0;
      SDMA_Req_o  <= 1'b0;
      SDMA_Sreq_o <= 1'b0;
      Err_Intr_o  <= 1'b0;
      Err_Src_o   <= '0;
    end else begin
      Done_o     <= '0;
      Err_Intr_o <= 1'b0;
      case (state)
        ST_IDLE:
          if (any) begin
            Grant_o     <= win;
            widx        <= idx;
            SDMA_Req_o  <= |(Req_i & win);
            SDMA_Sreq_o <= ~|(Req_i & win) & |(Sreq_i & win);
            cnt         <= '0;
            state       <= ST_REQ;
          end
        ST_REQ: begin
          cnt <= (&cnt) ? cnt : cnt + 1'b1;
          // Done beats Active, which beats withdrawal, which beats timeout
          if (SDMA_Done_i) begin
            SDMA_Req_o  <= 1'b0;
            SDMA_Sreq_o <= 1'b0;
            Done_o      <= Grant_o;
            state       <= ST_DONE;
          end else if (SDMA_Active_i) begin
            SDMA_Req_o  <= 1'b0;
            SDMA_Sreq_o <= 1'b0;
            state       <= ST_ACTIVE;
          end else if (!owner_req) begin
            SDMA_Req_o  <= 1'b0;
            SDMA_Sreq_o <= 1'b0;
            Grant_o     <= '0;
            state       <= ST_IDLE;
          end else if (cnt >= TIMEOUT_CYC - 1'b1) begin
            SDMA_Req_o  <= 1'b0;
            SDMA_Sreq_o <= 1'b0;
            Err_Intr_o  <= 1'b1;
            Err_Src_o   <= widx;
            state       <= ST_ERR;
          end
        end
        ST_ACTIVE:
          if (SDMA_Done_i) begin
            Done_o <= Grant_o;
            state  <= ST_DONE;
          end
        ST_DONE, ST_ERR: begin
          Grant_o <= '0;
          ptr     <= widx;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule
